// File: rtl/qarb_pkg.sv
// ---------------------------------------------------------------------------
// qarb_pkg : shared state encodings and index-wrap helper for queue_arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qarb_pkg;

   typedef enum logic [0:0] {
      QARB_IDLE  = 1'b0,
      QARB_OWNED = 1'b1
   } qarb_state_t;

   localparam int QARB_N_MIN = 2;
   localparam int QARB_N_MAX = 8;
   localparam int QARB_IDX_ZERO = 0;

   // Increment a requester index and wrap N-1 back to zero explicitly.
   function automatic int qarb_wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? QARB_IDX_ZERO : idx + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational masked round-robin search starting at index start
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
   import qarb_pkg::*;
#(
   parameter int N = 4
)(
   input  logic [N-1:0]         mask,
   input  logic [$clog2(N)-1:0] start,
   output logic                 valid,
   output logic [$clog2(N)-1:0] index
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] idx;

   always_comb begin
      valid = 1'b0;
      index = '0;
      idx   = start;
      for (int k = 0; k < N; k++) begin
         if (!valid && mask[idx]) begin
            valid = 1'b1;
            index = idx;
         end
         idx = IW'(qarb_wrap_inc(int'(idx), N));
      end
   end

endmodule

`default_nettype wire

// File: rtl/queue_arbiter.sv
// ---------------------------------------------------------------------------
// queue_arbiter : round-robin arbiter with locked bursts feeding a shared queue
// Revision : 1.0   (optional QARB_STATS_EN adds beat_count / stall_count)
// ---------------------------------------------------------------------------
`default_nettype none

module queue_arbiter
   import qarb_pkg::*;
#(
   parameter int N         = 4,
   parameter int WIDTH     = 16,
   parameter int MAX_BURST = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         lock,
   input  logic [N*WIDTH-1:0]   req_data,
   output logic [N-1:0]         ack,
   output logic                 q_push,
   output logic [WIDTH-1:0]     q_data,
   input  logic                 q_full,
   input  logic                 flush
`ifdef QARB_STATS_EN
   ,
   output logic [31:0]          beat_count,
   output logic [31:0]          stall_count
`endif
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_BURST + 1);

   qarb_state_t   state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] owner;
   logic [CW-1:0] cnt;

   logic [N-1:0]  eligible;
   logic [IW-1:0] start;
   logic [IW-1:0] win;
   logic          any;
   logic          fire;

   // While owned, only the owner's request is visible to the search.
   always_comb begin
      eligible = req;
      start    = ptr;
      if (state == QARB_OWNED) begin
         eligible        = '0;
         eligible[owner] = req[owner];
         start           = owner;
      end
   end

   rr_pick #(.N(N)) u_pick (
      .mask  (eligible),
      .start (start),
      .valid (any),
      .index (win)
   );

   always_comb begin
      fire     = any && !q_full && !flush && !reset;
      ack      = '0;
      ack[win] = fire;
      q_push   = fire;
      q_data   = req_data[int'(win)*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= QARB_IDLE;
         ptr   <= '0;
         owner <= '0;
         cnt   <= '0;
      end else if (flush) begin
         state <= QARB_IDLE;
         cnt   <= '0;
      end else if (!q_full) begin
         case (state)
            QARB_IDLE: begin
               if (fire) begin
                  if (lock[win] && (MAX_BURST > 1)) begin
                     state <= QARB_OWNED;
                     owner <= win;
                     cnt   <= CW'(1);
                  end else begin
                     ptr <= IW'(qarb_wrap_inc(int'(win), N));
                  end
               end
            end
            QARB_OWNED: begin
               if (fire) begin
                  if (cnt == CW'(MAX_BURST - 1)) begin
                     state <= QARB_IDLE;
                     cnt   <= '0;
                     ptr   <= IW'(qarb_wrap_inc(int'(owner), N));
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else if (!req[owner] || !lock[owner]) begin
                  state <= QARB_IDLE;
                  cnt   <= '0;
                  ptr   <= IW'(qarb_wrap_inc(int'(owner), N));
               end
            end
            default: begin
               state <= QARB_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef QARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_count  <= '0;
         stall_count <= '0;
      end else begin
         if (fire)
            beat_count <= beat_count + 32'd1;
         if (any && q_full && !flush)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_queue_arbiter : directed vector table plus queue-attached backpressure run
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_queue_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [63:0] req_data;
   logic [3:0]  ack;
   logic        q_push;
   logic [15:0] q_data;
   logic        q_full;
   logic        flush;
`ifdef QARB_STATS_EN
   logic [31:0] beat_count;
   logic [31:0] stall_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   queue_arbiter #(.N(4), .WIDTH(16), .MAX_BURST(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .lock        (lock),
      .req_data    (req_data),
      .ack         (ack),
      .q_push      (q_push),
      .q_data      (q_data),
      .q_full      (q_full),
      .flush       (flush)
`ifdef QARB_STATS_EN
      ,
      .beat_count  (beat_count),
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] lock;
      logic       full;
      logic       flush;
      logic       rst;
      logic [3:0] ack;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [3:0] r, input logic [3:0] l, input logic f,
                      input logic fl, input logic rs, input logic [3:0] a);
      vec_t v;
      v.req = r; v.lock = l; v.full = f; v.flush = fl; v.rst = rs; v.ack = a;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int r = 0;
      for (int i = 0; i < 4; i++)
         if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: actual running required finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int           rem [4];
      logic [15:0]  mem [$];
      logic [15:0]  exp_order [$];
      logic [15:0]  got;
      logic [15:0]  expd;
      int           pushes;
      int           w;
      int           cyc;
      logic         pop;

      //      req      lock     full  flush rst   ack
      add(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000); // reset
      add(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001); // plain round robin
      add(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010);
      add(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100);
      add(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000);
      add(4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001); // 4-beat locked burst
      add(4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001);
      add(4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001);
      add(4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001);
      add(4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0100);
      add(4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001);
      add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); // owner drops req
      add(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000); // full stall x3
      add(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
      add(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
      add(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010);
      add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); // idx 16: stats point
      add(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100); // owner 2, cnt 2
      add(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100);
      add(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000); // flush
      add(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100); // ptr still 2
      add(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010); // owner 1, cnt 3
      add(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
      add(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
      add(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000); // reset mid-burst
      add(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001);
      add(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010);

      reset    = 1'b1;
      req      = '0;
      lock     = '0;
      q_full   = 1'b0;
      flush    = 1'b0;
      req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      @(negedge clk);

      for (int k = 0; k < vq.size(); k++) begin
         req    = vq[k].req;
         lock   = vq[k].lock;
         q_full = vq[k].full;
         flush  = vq[k].flush;
         reset  = vq[k].rst;
         #1;
         check($sformatf("vec%0d_ack", k), 32'(ack), 32'(vq[k].ack));
         check($sformatf("vec%0d_push", k), 32'(q_push), 32'(|vq[k].ack));
         if (vq[k].ack != 4'b0000)
            check($sformatf("vec%0d_data", k), 32'(q_data),
                  32'(16'hA000 + 16'(onehot_idx(vq[k].ack))));
`ifdef QARB_STATS_EN
         if (k == 16) begin
            check("stats_beats", beat_count, 32'd11);
            check("stats_stalls", stall_count, 32'd3);
         end
`endif
         @(negedge clk);
      end

      // Shared two-entry queue with random pop backpressure.
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      flush = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) rem[i] = 3;
      pushes = 0;
      cyc    = 0;
      while ((pushes < 12 || mem.size() > 0) && cyc < 400) begin
         q_full = (mem.size() == 2);
         for (int i = 0; i < 4; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*16 +: 16] = 16'hB000 + 16'(i*16) + 16'(3 - rem[i]);
         end
         pop = 1'($urandom_range(0, 1));
         #1;
         check("rand_ack_vs_push", 32'(|ack), 32'(q_push));
         if (pop && mem.size() > 0) begin
            got  = mem.pop_front();
            expd = exp_order.pop_front();
            check("rand_pop_order", 32'(got), 32'(expd));
         end
         if (q_push) begin
            w = onehot_idx(ack);
            check("rand_ack_onehot", $countones(ack), 1);
            check("rand_push_when_full", 32'(q_full), 32'd0);
            check("rand_winner_req", 32'(req[w]), 32'd1);
            expd = 16'hB000 + 16'(w*16) + 16'(3 - rem[w]);
            check("rand_push_data", 32'(q_data), 32'(expd));
            exp_order.push_back(expd);
            mem.push_back(q_data);
            rem[w] = rem[w] - 1;
            pushes++;
         end
         cyc++;
         @(negedge clk);
      end
      check("rand_total_pushes", pushes, 12);
      check("rand_queue_drained", mem.size(), 0);
      check("rand_all_served", rem[0] + rem[1] + rem[2] + rem[3], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
